// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

    // Widest data word any instance may carry.
    localparam int MAX_DATA_BITS = 9;

    // Parity bit a sender must emit for this data (zero-extended words give the same result).
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // True when the parameter set describes a frame format the receiver supports.
    function automatic bit params_ok(input int data_bits, input int oversample,
                                     input int parity_en, input int parity_odd,
                                     input int stop_bits);
        return (data_bits >= 5) && (data_bits <= MAX_DATA_BITS) &&
               (oversample >= 8) && ((oversample % 2) == 0) &&
               ((parity_en == 0) || (parity_en == 1)) &&
               ((parity_odd == 0) || (parity_odd == 1)) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous line; resets to 1 so
// releasing reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: plain two-stage shift.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser flops, reset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with 3-sample majority vote,
// optional parity, 1/2 stop bits, break detection and a valid/ready output register.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 rx_clk,
    input  logic                 reset_n,
    input  logic                 rx_serial,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun_error,
    output logic                 break_detect,
    output logic                 busy
);
    import uart_pkg::*;

    if (!params_ok(DATA_BITS, OVERSAMPLE, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_param_check
        $error("uart_rx_param: unsupported parameter set");
    end

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [TW-1:0] TICK_LO   = TW'(M - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(M);
    localparam logic [TW-1:0] TICK_HI   = TW'(M + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    logic                     rx_s;
    rx_state_t                state_q, state_d;
    logic [TW-1:0]            tick_q, tick_d, tick_inc_s;
    logic [3:0]               bit_q, bit_d;
    logic [DATA_BITS-1:0]     shreg_q, shreg_d, rx_data_q, rx_data_d;
    logic                     smp0_q, smp0_d, smp1_q, smp1_d;
    logic                     par_bit_q, par_bit_d, fr_err_q, fr_err_d, par_err_q, par_err_d;
    logic                     rx_valid_q, rx_valid_d, fe_q, fe_d, pe_q, pe_d;
    logic                     ovr_q, ovr_d, brk_q, brk_d;
    logic                     vote_s, vote_tick_s, stop_low_s, deliver_s, is_break_s;
    logic [MAX_DATA_BITS-1:0] par_src_s;

    uart_rx_sync u_sync (
        .clk   (rx_clk),
        .rst_n (reset_n),
        .d     (rx_serial),
        .q     (rx_s)
    );

    // Bit-timing helpers: wrapping tick counter, centre samples and majority vote.
    always_comb begin
        tick_inc_s  = (tick_q == TICK_LAST) ? {TW{1'b0}} : tick_q + TW'(1);
        vote_tick_s = (tick_q == TICK_HI);
        vote_s      = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
        stop_low_s  = fr_err_q | ~vote_s;
        is_break_s  = stop_low_s && (shreg_q == {DATA_BITS{1'b0}}) && !par_bit_q;
        smp0_d      = (tick_q == TICK_LO)  ? rx_s : smp0_q;
        smp1_d      = (tick_q == TICK_MID) ? rx_s : smp1_q;
        par_src_s   = {MAX_DATA_BITS{1'b0}};
        par_src_s[DATA_BITS-1:0] = shreg_q;
    end

    // Frame FSM: next state, shift register, per-frame status and break pulse.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        fr_err_d  = fr_err_q;
        par_err_d = par_err_q;
        brk_d     = 1'b0;
        deliver_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    tick_d    = {TW{1'b0}};
                    fr_err_d  = 1'b0;
                    par_err_d = 1'b0;
                    par_bit_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                tick_d = tick_inc_s;
                if (vote_tick_s) begin
                    state_d = vote_s ? IDLE : DATA;
                    bit_d   = 4'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                tick_d = tick_inc_s;
                if (vote_tick_s) begin
                    shreg_d = {vote_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                tick_d = tick_inc_s;
                if (vote_tick_s) begin
                    par_bit_d = vote_s;
                    par_err_d = (vote_s != calc_parity(par_src_s, ODD_BIT));
                    bit_d     = 4'd0;
                    state_d   = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                tick_d = tick_inc_s;
                if (vote_tick_s) begin
                    fr_err_d = stop_low_s;
                    if (bit_q != LAST_STOP) begin
                        bit_d = bit_q + 4'd1;
                    end else if (is_break_s) begin
                        brk_d   = 1'b1;
                        tick_d  = {TW{1'b0}};
                        state_d = BRK_WAIT;
                    end else begin
                        deliver_s = 1'b1;
                        tick_d    = {TW{1'b0}};
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            BRK_WAIT: begin
                // tick_cnt doubles as the count of consecutive high samples.
                if (!rx_s) begin
                    tick_d = {TW{1'b0}};
                end else if (tick_q == TICK_LO) begin
                    tick_d  = {TW{1'b0}};
                    state_d = IDLE;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = {TW{1'b0}};
            end
        endcase
    end

    // Output holding register: load on delivery, clear on accept, flag overrun when full.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        fe_d       = fe_q;
        pe_d       = pe_q;
        ovr_d      = 1'b0;
        if (deliver_s) begin
            if (rx_valid_q && !rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
                fe_d       = stop_low_s;
                pe_d       = par_err_q;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tick_q     <= {TW{1'b0}};
            bit_q      <= 4'd0;
            shreg_q    <= {DATA_BITS{1'b0}};
            smp0_q     <= 1'b0;
            smp1_q     <= 1'b0;
            par_bit_q  <= 1'b0;
            fr_err_q   <= 1'b0;
            par_err_q  <= 1'b0;
            rx_data_q  <= {DATA_BITS{1'b0}};
            rx_valid_q <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            smp0_q     <= smp0_d;
            smp1_q     <= smp1_d;
            par_bit_q  <= par_bit_d;
            fr_err_q   <= fr_err_d;
            par_err_q  <= par_err_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = fe_q;
    assign parity_error  = pe_q;
    assign overrun_error = ovr_q;
    assign break_detect  = brk_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: u0 is the default 8N1 receiver, u1 runs
// 8 data bits, even parity and 2 stop bits. Both oversample by 16.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser0, ser1, rdy0, rdy1;
    logic [7:0] data0, data1;
    logic       val0, fe0, pe0, ovr0, brk0, busy0;
    logic       val1, fe1, pe1, ovr1, brk1, busy1;

    int cyc = 0;
    int checks = 0;
    int fails = 0;
    int rise0 = 0, rise1 = 0, rise_cyc0 = 0, rise_cyc1 = 0;
    int ovr_c0 = 0, ovr_c1 = 0, brk_c0 = 0, brk_c1 = 0;
    logic pv0 = 1'b0, pv1 = 1'b0;

    uart_rx_param u0 (
        .rx_clk(clk), .reset_n(rst_n), .rx_serial(ser0), .rx_ready(rdy0),
        .rx_data(data0), .rx_valid(val0), .framing_error(fe0), .parity_error(pe0),
        .overrun_error(ovr0), .break_detect(brk0), .busy(busy0)
    );

    uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .rx_clk(clk), .reset_n(rst_n), .rx_serial(ser1), .rx_ready(rdy1),
        .rx_data(data1), .rx_valid(val1), .framing_error(fe1), .parity_error(pe1),
        .overrun_error(ovr1), .break_detect(brk1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitors: rx_valid rising edges, overrun and break pulses.
    always @(posedge clk) begin
        #1;
        if (val0 && !pv0) begin rise0 <= rise0 + 1; rise_cyc0 <= cyc; end
        if (val1 && !pv1) begin rise1 <= rise1 + 1; rise_cyc1 <= cyc; end
        pv0 <= val0;
        pv1 <= val1;
        if (ovr0) ovr_c0 <= ovr_c0 + 1;
        if (ovr1) ovr_c1 <= ovr_c1 + 1;
        if (brk0) brk_c0 <= brk_c0 + 1;
        if (brk1) brk_c1 <= brk_c1 + 1;
    end

    task automatic set_line(input int which, input logic v);
        if (which == 0) ser0 = v; else ser1 = v;
    endtask

    // bits[0] is the start bit; each bit lasts 16 clocks; optional one-clock low spike.
    task automatic drive_frame(input int which, input logic [11:0] bits, input int nbits,
                               input int spike_bit, input int spike_slot, output int c0);
        c0 = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                if (b == 0 && s == 0) c0 = cyc;
                set_line(which, (b == spike_bit && s == spike_slot) ? 1'b0 : bits[b]);
            end
        end
        @(negedge clk);
        set_line(which, 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({val0, fe0, pe0, ovr0, brk0, busy0} !== 6'b0) begin fails++; $display("FAIL reset_u0_flags: got %b want 000000", {val0, fe0, pe0, ovr0, brk0, busy0}); end
        checks++; if (data0 !== 8'h00) begin fails++; $display("FAIL reset_u0_data: got %h want 00", data0); end
        checks++; if ({val1, fe1, pe1, ovr1, brk1, busy1} !== 6'b0) begin fails++; $display("FAIL reset_u1_flags: got %b want 000000", {val1, fe1, pe1, ovr1, brk1, busy1}); end
        checks++; if (data1 !== 8'h00) begin fails++; $display("FAIL reset_u1_data: got %h want 00", data1); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b want 0", busy0); end
    endtask

    task automatic test_basic();
        int c0, r0, o0;
        r0 = rise0; o0 = ovr_c0; rdy0 = 1'b1;
        drive_frame(0, {2'b11, 1'b1, 8'hA5, 1'b0}, 10, -1, 0, c0);
        repeat (4) @(negedge clk);
        checks++; if (rise0 - r0 !== 1) begin fails++; $display("FAIL basic_valid_count: got %0d want 1", rise0 - r0); end
        checks++; if (data0 !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", data0); end
        checks++; if ({fe0, pe0} !== 2'b00) begin fails++; $display("FAIL basic_flags: got %b want 00", {fe0, pe0}); end
        checks++; if (rise_cyc0 !== c0 + 157) begin fails++; $display("FAIL basic_latency: got cycle %0d want %0d", rise_cyc0, c0 + 157); end
        checks++; if (val0 !== 1'b0) begin fails++; $display("FAIL basic_valid_cleared: got %b want 0", val0); end
        checks++; if (ovr_c0 - o0 !== 0) begin fails++; $display("FAIL basic_no_overrun: got %0d want 0", ovr_c0 - o0); end
    endtask

    task automatic test_glitch();
        int c0, r0;
        r0 = rise0;
        @(negedge clk); c0 = cyc; ser0 = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); ser0 = 1'b1;
        while (cyc < c0 + 5) @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin fails++; $display("FAIL glitch_busy_rise: got %b want 1", busy0); end
        while (cyc < c0 + 12) @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin fails++; $display("FAIL glitch_busy_at_vote: got %b want 1", busy0); end
        @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin fails++; $display("FAIL glitch_busy_fall: got %b want 0", busy0); end
        repeat (20) @(negedge clk);
        checks++; if (rise0 - r0 !== 0) begin fails++; $display("FAIL glitch_no_valid: got %0d want 0", rise0 - r0); end
    endtask

    task automatic test_spike();
        int c0, r0;
        r0 = rise0;
        drive_frame(0, {2'b11, 1'b1, 8'hFF, 1'b0}, 10, 4, 9, c0);
        repeat (4) @(negedge clk);
        checks++; if (rise0 - r0 !== 1) begin fails++; $display("FAIL spike_valid_count: got %0d want 1", rise0 - r0); end
        checks++; if (data0 !== 8'hFF) begin fails++; $display("FAIL spike_data: got %h want ff", data0); end
    endtask

    task automatic test_back_to_back();
        int c0, c1, r0;
        r0 = rise0;
        drive_frame(0, {2'b11, 1'b1, 8'h01, 1'b0}, 10, -1, 0, c0);
        drive_frame(0, {2'b11, 1'b1, 8'h80, 1'b0}, 10, -1, 0, c1);
        repeat (4) @(negedge clk);
        checks++; if (rise0 - r0 !== 2) begin fails++; $display("FAIL b2b_valid_count: got %0d want 2", rise0 - r0); end
        checks++; if (data0 !== 8'h80) begin fails++; $display("FAIL b2b_data: got %h want 80", data0); end
        checks++; if (rise_cyc0 !== c1 + 157) begin fails++; $display("FAIL b2b_latency: got cycle %0d want %0d", rise_cyc0, c1 + 157); end
    endtask

    task automatic test_overrun();
        int c0, r0, o0;
        r0 = rise0; o0 = ovr_c0; rdy0 = 1'b0;
        drive_frame(0, {2'b11, 1'b1, 8'h11, 1'b0}, 10, -1, 0, c0);
        drive_frame(0, {2'b11, 1'b1, 8'h22, 1'b0}, 10, -1, 0, c0);
        repeat (4) @(negedge clk);
        checks++; if (val0 !== 1'b1) begin fails++; $display("FAIL ovr_valid_held: got %b want 1", val0); end
        checks++; if (data0 !== 8'h11) begin fails++; $display("FAIL ovr_data_held: got %h want 11", data0); end
        checks++; if ({fe0, pe0} !== 2'b00) begin fails++; $display("FAIL ovr_flags_held: got %b want 00", {fe0, pe0}); end
        checks++; if (ovr_c0 - o0 !== 1) begin fails++; $display("FAIL ovr_pulse_count: got %0d want 1", ovr_c0 - o0); end
        checks++; if (rise0 - r0 !== 1) begin fails++; $display("FAIL ovr_valid_count: got %0d want 1", rise0 - r0); end
        rdy0 = 1'b1;
        @(negedge clk);
        checks++; if (val0 !== 1'b0) begin fails++; $display("FAIL ovr_accept_clears: got %b want 0", val0); end
    endtask

    task automatic test_break();
        int c0, r0, b0;
        r0 = rise0; b0 = brk_c0; rdy0 = 1'b1;
        @(negedge clk); ser0 = 1'b0;
        repeat (320) @(negedge clk);
        ser0 = 1'b1;
        repeat (48) @(negedge clk);
        checks++; if (brk_c0 - b0 !== 1) begin fails++; $display("FAIL break_pulse_count: got %0d want 1", brk_c0 - b0); end
        checks++; if (rise0 - r0 !== 0) begin fails++; $display("FAIL break_not_delivered: got %0d want 0", rise0 - r0); end
        checks++; if (busy0 !== 1'b0) begin fails++; $display("FAIL break_back_idle: got %b want 0", busy0); end
        drive_frame(0, {2'b11, 1'b1, 8'h5A, 1'b0}, 10, -1, 0, c0);
        repeat (4) @(negedge clk);
        checks++; if (rise0 - r0 !== 1) begin fails++; $display("FAIL break_next_valid: got %0d want 1", rise0 - r0); end
        checks++; if (data0 !== 8'h5A) begin fails++; $display("FAIL break_next_data: got %h want 5a", data0); end
        checks++; if (brk_c0 - b0 !== 1) begin fails++; $display("FAIL break_single: got %0d want 1", brk_c0 - b0); end
    endtask

    task automatic test_parity();
        int c0, r1;
        r1 = rise1;
        drive_frame(1, {1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 12, -1, 0, c0);
        repeat (4) @(negedge clk);
        checks++; if (rise1 - r1 !== 1) begin fails++; $display("FAIL par_bad_valid: got %0d want 1", rise1 - r1); end
        checks++; if (data1 !== 8'h3C) begin fails++; $display("FAIL par_bad_data: got %h want 3c", data1); end
        checks++; if ({fe1, pe1} !== 2'b01) begin fails++; $display("FAIL par_bad_flags: got fe,pe=%b want 01", {fe1, pe1}); end
        checks++; if (rise_cyc1 !== c0 + 189) begin fails++; $display("FAIL par_latency: got cycle %0d want %0d", rise_cyc1, c0 + 189); end
        drive_frame(1, {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}, 12, -1, 0, c0);
        repeat (4) @(negedge clk);
        checks++; if (rise1 - r1 !== 2) begin fails++; $display("FAIL par_good_valid: got %0d want 2", rise1 - r1); end
        checks++; if ({fe1, pe1} !== 2'b00) begin fails++; $display("FAIL par_good_flags: got fe,pe=%b want 00", {fe1, pe1}); end
    endtask

    task automatic test_stop2();
        int c0, r1, b1, o1;
        r1 = rise1; b1 = brk_c1; o1 = ovr_c1;
        drive_frame(1, {1'b0, 1'b1, 1'b0, 8'h7E, 1'b0}, 12, -1, 0, c0);
        repeat (4) @(negedge clk);
        checks++; if (rise1 - r1 !== 1) begin fails++; $display("FAIL stop2_valid: got %0d want 1", rise1 - r1); end
        checks++; if (data1 !== 8'h7E) begin fails++; $display("FAIL stop2_data: got %h want 7e", data1); end
        checks++; if ({fe1, pe1} !== 2'b10) begin fails++; $display("FAIL stop2_flags: got fe,pe=%b want 10", {fe1, pe1}); end
        checks++; if (brk_c1 - b1 !== 0) begin fails++; $display("FAIL stop2_no_break: got %0d want 0", brk_c1 - b1); end
        repeat (30) @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin fails++; $display("FAIL stop2_idle_after: got %b want 0", busy1); end
        checks++; if ((rise1 - r1 !== 1) || (ovr_c1 - o1 !== 0)) begin fails++; $display("FAIL stop2_no_extra: got valid %0d ovr %0d want 1 0", rise1 - r1, ovr_c1 - o1); end
    endtask

    task automatic test_reset_mid();
        int c0, r0;
        rdy0 = 1'b0;
        drive_frame(0, {2'b11, 1'b1, 8'h33, 1'b0}, 10, -1, 0, c0);
        repeat (4) @(negedge clk);
        checks++; if ({val0, data0} !== {1'b1, 8'h33}) begin fails++; $display("FAIL rmid_preload: got %b/%h want 1/33", val0, data0); end
        @(negedge clk); ser0 = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin fails++; $display("FAIL rmid_in_frame: got %b want 1", busy0); end
        ser0 = 1'b1; rst_n = 1'b0;
        #1;
        checks++; if ({val0, fe0, pe0, ovr0, brk0, busy0} !== 6'b0) begin fails++; $display("FAIL rmid_flags_zero: got %b want 000000", {val0, fe0, pe0, ovr0, brk0, busy0}); end
        checks++; if (data0 !== 8'h00) begin fails++; $display("FAIL rmid_data_zero: got %h want 00", data0); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rdy0 = 1'b1;
        repeat (5) @(negedge clk);
        r0 = rise0;
        drive_frame(0, {2'b11, 1'b1, 8'hC3, 1'b0}, 10, -1, 0, c0);
        repeat (4) @(negedge clk);
        checks++; if (rise0 - r0 !== 1) begin fails++; $display("FAIL rmid_next_valid: got %0d want 1", rise0 - r0); end
        checks++; if (data0 !== 8'hC3) begin fails++; $display("FAIL rmid_next_data: got %h want c3", data0); end
        checks++; if ({fe0, pe0} !== 2'b00) begin fails++; $display("FAIL rmid_next_flags: got %b want 00", {fe0, pe0}); end
    endtask

    initial begin
        rst_n = 1'b0;
        ser0 = 1'b1; ser1 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_spike();
        test_back_to_back();
        test_overrun();
        test_break();
        test_parity();
        test_stop2();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver, generalised for the serial links in the UART subsystem. It oversamples the asynchronous rx_serial line and supports configurable data width, optional parity and 1 or 2 stop bits. Each bit is sampled by 3-sample majority vote. Received frames go to the consumer through a valid/ready holding register, with framing, parity, overrun and break status.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
OVERSAMPLE, 16, rx_clk ticks per bit, even, >= 8
PARITY_EN, 0, 1 = parity bit present after the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
rx_clk  input  1  oversampling clock, the only clock
reset_n  input  1  asynchronous, active-low reset
rx_serial  input  1  asynchronous serial line, idles high
rx_ready  input  1  consumer accepts rx_data when high with rx_valid
rx_data  output  DATA_BITS  received data word
rx_valid  output  1  holding register full
framing_error  output  1  frame status, qualified by rx_valid
parity_error  output  1  frame status, qualified by rx_valid
overrun_error  output  1  1-cycle pulse: completed frame dropped
break_detect  output  1  1-cycle pulse: break condition detected
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0; rx_data 0; state IDLE; counters 0.
  - Synchroniser flops reset to 1, so no false start on release.
- Input path: 2-flop synchroniser; all logic uses the synchronised line (2-cycle input latency).
- tick_cnt width is $clog2(OVERSAMPLE). Majority vote uses the 3 samples at ticks M-1, M, M+1, with M = OVERSAMPLE/2.
- IDLE: synchronised line low -> START, tick_cnt=0.
- START: count ticks; at tick M+1 evaluate the vote.
  - Vote low -> DATA, bit_cnt=0, tick_cnt realigned so the next vote is centred one bit later.
  - Vote high -> IDLE (glitch rejection, no status).
- DATA: one vote per bit every OVERSAMPLE ticks; result shifted in LSB first.
  - After bit DATA_BITS-1: go to PARITY if PARITY_EN, else STOP.
- PARITY: vote the parity bit. parity_err_q = (XOR of data bits XOR parity bit) != PARITY_ODD.
- STOP: vote each stop bit; any stop vote low sets fr_err_q.
  - Decision is taken at the vote of the last stop bit. No wait to the bit end: IDLE is entered the same cycle, allowing back-to-back frames.
- Break: stop vote low, all data bits 0 and parity bit (if present) 0.
  - break_detect pulses 1 cycle, frame is not delivered, go to BRK_WAIT.
  - BRK_WAIT: stay until the synchronised line is high for M consecutive ticks, then IDLE.
- Delivery: the cycle after the decision, rx_data / framing_error / parity_error are loaded and rx_valid=1.
  - Frames with a framing or parity error are still delivered, flags set.
  - Latency: rx_valid rises 1 rx_clk after the final stop-bit vote tick.
- Handshake:
  - rx_valid & rx_ready clears rx_valid next cycle, unless a frame is delivered the same cycle; then the new frame loads and rx_valid stays 1.
  - Frame completes while rx_valid=1 and rx_ready=0: the new frame is dropped, held data and flags are unchanged, overrun_error pulses 1 cycle.
  - rx_data and flags are stable while rx_valid=1 and not accepted.
- Simultaneous events: break wins over delivery; reset wins over everything.
- Reset mid-frame: frame discarded; after release the receiver waits in IDLE for the next falling edge.

Decomposition:
- uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - Function calc_parity(data, odd).
  - Parameter legality checks as elaboration-time asserts.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset value 1, reusable by the transmitter loopback test.
- Majority vote and counters stay inline.

Test Plan:
- Default 8N1, send 0xA5 at OVERSAMPLE=16, rx_ready=1 -> rx_valid pulses once, rx_data=0xA5, all flags 0, rx_valid rises 1 cycle after the stop vote.
- Low glitch of 4 ticks on an idle line -> busy rises then falls by tick 9, no rx_valid.
- Single-tick low spike at data-bit tick M -> bit read correctly (majority), data intact.
- PARITY_EN=1, PARITY_ODD=0, 0x3C sent with parity 1 -> rx_data=0x3C, parity_error=1; same frame with parity 0 -> parity_error=0.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_error pulses once at the second frame; raise rx_ready -> rx_valid drops.
- Line held low for 20 bit times, then high, then 0x5A sent -> break_detect pulses once, no rx_valid for the break, then 0x5A received.
- STOP_BITS=2, second stop bit low with 0x7E -> rx_data=0x7E, framing_error=1.
- reset_n asserted mid-DATA -> all outputs 0 immediately; the next frame 0xC3 is received correctly.
